// File: rtl/clic_hart_if.sv
// Hart-side CLIC claim/trap handshake with interrupt-level nesting.
// Define CLIC_HART_NEST_STACK_EN for a NEST_DEPTH-entry saved-level stack; otherwise a single saved level (no nesting).
module clic_hart_if #(
  parameter int CLICINTCTLBITS = 8,
  parameter int NUM_INTR       = 1024,
  parameter int NEST_DEPTH     = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      irq_valid_i,
  input  logic [$clog2(NUM_INTR)-1:0] irq_id_i,
  input  logic [CLICINTCTLBITS-1:0] irq_level_i,
  input  logic [1:0]                irq_mode_i,
  input  logic                      irq_shv_i,
  output logic                      irq_ready_o,
  input  logic                      mie_i,
  input  logic [CLICINTCTLBITS-1:0] mintthresh_i,
  output logic                      trap_req_o,
  output logic [$clog2(NUM_INTR)-1:0] trap_id_o,
  output logic [CLICINTCTLBITS-1:0] trap_level_o,
  output logic [1:0]                trap_mode_o,
  output logic                      trap_shv_o,
  input  logic                      trap_ack_i,
  input  logic                      mret_i,
  output logic [CLICINTCTLBITS-1:0] mil_o
);

  localparam int IDW = $clog2(NUM_INTR);
`ifdef CLIC_HART_NEST_STACK_EN
  localparam int DEPTH = NEST_DEPTH;
`else
  localparam int DEPTH = 1;
`endif
  localparam int SPW = $clog2(DEPTH + 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_TRAP = 1'b1;

  if (NEST_DEPTH < 1) begin : g_bad_depth
    $error("clic_hart_if: NEST_DEPTH must be at least 1");
  end

  logic [0:0]                r_state;
  logic [SPW-1:0]            r_sp;
  logic [CLICINTCTLBITS-1:0] r_mil;
  logic [CLICINTCTLBITS-1:0] r_stack [DEPTH];
  logic [IDW-1:0]            r_trap_id;
  logic [CLICINTCTLBITS-1:0] r_trap_level;
  logic [1:0]                r_trap_mode;
  logic                      r_trap_shv;

  logic [CLICINTCTLBITS-1:0] w_floor;
  logic [CLICINTCTLBITS-1:0] w_pop_val;
  logic                      w_full;
  logic                      w_accept;
  logic                      w_ack;

  assign w_floor = (r_mil > mintthresh_i) ? r_mil : mintthresh_i;
  assign w_full  = (r_sp == SPW'(DEPTH));
  // rst_n gates the claim so no ready pulse can escape while reset is held
  assign w_accept = rst_n && (r_state == ST_IDLE) && irq_valid_i && mie_i &&
                    (irq_level_i > w_floor) && !w_full;
  assign w_ack    = (r_state == ST_TRAP) && trap_ack_i;

  always_comb begin
    w_pop_val = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (r_sp == SPW'(k + 1)) w_pop_val = r_stack[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_sp         <= '0;
      r_mil        <= '0;
      r_trap_id    <= '0;
      r_trap_level <= '0;
      r_trap_mode  <= '0;
      r_trap_shv   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_state      <= ST_TRAP;
        r_trap_id    <= irq_id_i;
        r_trap_level <= irq_level_i;
        r_trap_mode  <= irq_mode_i;
        r_trap_shv   <= irq_shv_i;
      end else if (w_ack) begin
        r_state <= ST_IDLE;
      end
      // ack wins over a coincident mret
      if (w_ack) begin
        r_sp  <= r_sp + SPW'(1);
        r_mil <= r_trap_level;
      end else if (mret_i) begin
        if (r_sp != '0) begin
          r_sp  <= r_sp - SPW'(1);
          r_mil <= w_pop_val;
        end else begin
          r_mil <= '0;
        end
      end
    end
  end

  // Saved-level storage carries data only; emptiness is tracked by r_sp
  always_ff @(posedge clk) begin
    for (int k = 0; k < DEPTH; k++) begin
      if (w_ack && (r_sp == SPW'(k))) r_stack[k] <= r_mil;
    end
  end

  assign irq_ready_o  = w_accept;
  assign trap_req_o   = (r_state == ST_TRAP);
  assign trap_id_o    = r_trap_id;
  assign trap_level_o = r_trap_level;
  assign trap_mode_o  = r_trap_mode;
  assign trap_shv_o   = r_trap_shv;
  assign mil_o        = r_mil;

endmodule

// File: tb/tb_clic_hart_if.sv
// Directed-vector bench for clic_hart_if; follows CLIC_HART_NEST_STACK_EN like the design.
module tb_clic_hart_if;

  localparam int W        = 8;
  localparam int NUM_INTR = 1024;
  localparam int IDW      = 10;
`ifdef CLIC_HART_NEST_STACK_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif

  logic           clk;
  logic           rst_n;
  logic           irq_valid_i;
  logic [IDW-1:0] irq_id_i;
  logic [W-1:0]   irq_level_i;
  logic [1:0]     irq_mode_i;
  logic           irq_shv_i;
  logic           irq_ready_o;
  logic           mie_i;
  logic [W-1:0]   mintthresh_i;
  logic           trap_req_o;
  logic [IDW-1:0] trap_id_o;
  logic [W-1:0]   trap_level_o;
  logic [1:0]     trap_mode_o;
  logic           trap_shv_o;
  logic           trap_ack_i;
  logic           mret_i;
  logic [W-1:0]   mil_o;

  int n_vec = 0;
  int n_err = 0;

  clic_hart_if #(
    .CLICINTCTLBITS(W),
    .NUM_INTR      (NUM_INTR),
    .NEST_DEPTH    (4)
  ) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .irq_valid_i (irq_valid_i),
    .irq_id_i    (irq_id_i),
    .irq_level_i (irq_level_i),
    .irq_mode_i  (irq_mode_i),
    .irq_shv_i   (irq_shv_i),
    .irq_ready_o (irq_ready_o),
    .mie_i       (mie_i),
    .mintthresh_i(mintthresh_i),
    .trap_req_o  (trap_req_o),
    .trap_id_o   (trap_id_o),
    .trap_level_o(trap_level_o),
    .trap_mode_o (trap_mode_o),
    .trap_shv_o  (trap_shv_o),
    .trap_ack_i  (trap_ack_i),
    .mret_i      (mret_i),
    .mil_o       (mil_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_mret(input logic [W-1:0] exp_mil);
    mret_i = 1'b1;
    step();
    mret_i = 1'b0;
    check("mret_mil", mil_o, exp_mil);
  endtask

  // Full claim: accept, check captured fields, ack (optionally with a coincident mret)
  task automatic claim(input logic [IDW-1:0] id, input logic [W-1:0] lvl, input logic with_mret);
    irq_valid_i = 1'b1;
    irq_id_i    = id;
    irq_level_i = lvl;
    irq_mode_i  = 2'b11;
    irq_shv_i   = id[0];
    #1;
    check("claim_ready", irq_ready_o, 1);
    step();
    check("claim_req", trap_req_o, 1);
    check("claim_id", trap_id_o, id);
    check("claim_lvl", trap_level_o, lvl);
    check("claim_shv", trap_shv_o, id[0]);
    check("claim_ready_once", irq_ready_o, 0);
    irq_valid_i = 1'b0;
    trap_ack_i  = 1'b1;
    mret_i      = with_mret;
    step();
    trap_ack_i  = 1'b0;
    mret_i      = 1'b0;
    check("ack_req_drop", trap_req_o, 0);
    check("ack_mil", mil_o, lvl);
  endtask

  initial begin
    rst_n        = 1'b0;
    irq_valid_i  = 1'b0;
    irq_id_i     = '0;
    irq_level_i  = '0;
    irq_mode_i   = '0;
    irq_shv_i    = 1'b0;
    mie_i        = 1'b0;
    mintthresh_i = '0;
    trap_ack_i   = 1'b0;
    mret_i       = 1'b0;
    #2;
    check("rst_req", trap_req_o, 0);
    check("rst_ready", irq_ready_o, 0);
    check("rst_mil", mil_o, 0);
    check("rst_id", trap_id_o, 0);
    #10 rst_n = 1'b1;
    step();

    // Basic claim id 5 level 0x40, with mie/thresh wiggling in TRAP
    mie_i       = 1'b1;
    irq_valid_i = 1'b1;
    irq_id_i    = 10'd5;
    irq_level_i = 8'h40;
    irq_mode_i  = 2'b11;
    irq_shv_i   = 1'b1;
    #1;
    check("t1_ready", irq_ready_o, 1);
    step();
    irq_valid_i = 1'b0;
    check("t1_req", trap_req_o, 1);
    check("t1_id", trap_id_o, 5);
    check("t1_mode", trap_mode_o, 3);
    check("t1_shv", trap_shv_o, 1);
    check("t1_ready_pulse", irq_ready_o, 0);
    mie_i        = 1'b0;
    mintthresh_i = 8'hFF;
    step();
    check("t1_hold_req", trap_req_o, 1);
    check("t1_hold_lvl", trap_level_o, 8'h40);
    check("t1_hold_mil", mil_o, 0);
    mie_i        = 1'b1;
    mintthresh_i = 8'h00;
    trap_ack_i   = 1'b1;
    step();
    trap_ack_i   = 1'b0;
    check("t1_req_drop", trap_req_o, 0);
    check("t1_mil", mil_o, 8'h40);

    // Equal level is not above mil
    irq_valid_i = 1'b1;
    irq_id_i    = 10'd7;
    irq_level_i = 8'h40;
    #1;
    check("t2_eq_ready", irq_ready_o, 0);
    step();
    check("t2_eq_req", trap_req_o, 0);
    irq_valid_i = 1'b0;
`ifdef CLIC_HART_NEST_STACK_EN
    claim(10'd7, 8'h41, 1'b0);
    do_mret(8'h40);
    do_mret(8'h00);
`else
    irq_valid_i = 1'b1;
    irq_level_i = 8'h41;
    #1;
    check("t2_nonest_ready", irq_ready_o, 0);
    step();
    check("t2_nonest_req", trap_req_o, 0);
    irq_valid_i = 1'b0;
    do_mret(8'h00);
    claim(10'd7, 8'h41, 1'b0);
    do_mret(8'h00);
`endif

    // Threshold and global enable
    mintthresh_i = 8'h80;
    irq_valid_i  = 1'b1;
    irq_id_i     = 10'd9;
    irq_level_i  = 8'h7F;
    #1;
    check("t3_below_ready", irq_ready_o, 0);
    step();
    check("t3_below_req", trap_req_o, 0);
    irq_level_i = 8'h80;
    #1;
    check("t3_eq_thr_ready", irq_ready_o, 0);
    irq_level_i = 8'hFF;
    mie_i       = 1'b0;
    #1;
    check("t3_mie0_ready", irq_ready_o, 0);
    step();
    check("t3_mie0_req", trap_req_o, 0);
    mie_i       = 1'b1;
    irq_valid_i = 1'b0;
    claim(10'd9, 8'h81, 1'b0);
    do_mret(8'h00);
    mintthresh_i = 8'h00;
    trap_ack_i   = 1'b1;
    step();
    trap_ack_i   = 1'b0;
    check("t3_stray_ack_mil", mil_o, 0);
    check("t3_stray_ack_req", trap_req_o, 0);

    // Fill saved levels, then a higher request waits for an mret
    for (int k = 0; k < DEPTH; k++) claim(IDW'(k + 1), W'(8'h10 * (k + 1)), 1'b0);
    irq_valid_i = 1'b1;
    irq_id_i    = 10'h55;
    irq_level_i = 8'hF0;
    #1;
    check("t4_full_ready", irq_ready_o, 0);
    step();
    check("t4_full_ready2", irq_ready_o, 0);
    check("t4_full_req", trap_req_o, 0);
    mret_i = 1'b1;
    #1;
    check("t4_mret_cyc_ready", irq_ready_o, 0);
    step();
    mret_i = 1'b0;
    check("t4_pop_mil", mil_o, W'(8'h10 * (DEPTH - 1)));
    check("t4_after_pop_ready", irq_ready_o, 1);
    step();
    irq_valid_i = 1'b0;
    check("t4_req", trap_req_o, 1);
    check("t4_id", trap_id_o, 10'h55);
    trap_ack_i = 1'b1;
    step();
    trap_ack_i = 1'b0;
    check("t4_ack_mil", mil_o, 8'hF0);
    for (int j = 0; j < DEPTH; j++) do_mret(W'(8'h10 * (DEPTH - 1 - j)));
    do_mret(8'h00);

    // ack and mret in the same cycle: ack wins
    claim(10'h21, 8'h50, 1'b1);
    do_mret(8'h00);
`ifdef CLIC_HART_NEST_STACK_EN
    claim(10'h20, 8'h20, 1'b0);
    claim(10'h21, 8'h50, 1'b1);
    do_mret(8'h20);
    do_mret(8'h00);
    do_mret(8'h00);
    // mret while trap pending pops but keeps the request
    claim(10'h20, 8'h20, 1'b0);
    irq_valid_i = 1'b1;
    irq_id_i    = 10'h22;
    irq_level_i = 8'h50;
    #1;
    check("t5_ready", irq_ready_o, 1);
    step();
    irq_valid_i = 1'b0;
    do_mret(8'h00);
    check("t5_pend_req", trap_req_o, 1);
    check("t5_pend_lvl", trap_level_o, 8'h50);
    trap_ack_i = 1'b1;
    step();
    trap_ack_i = 1'b0;
    check("t5_ack_mil", mil_o, 8'h50);
    do_mret(8'h00);
    claim(10'h30, 8'h30, 1'b0);
`endif

    // Reset in the middle of a pending trap
    irq_valid_i = 1'b1;
    irq_id_i    = 10'h3FF;
    irq_level_i = 8'h7F;
    irq_mode_i  = 2'b10;
    irq_shv_i   = 1'b1;
    #1;
    check("t6_ready", irq_ready_o, 1);
    step();
    check("t6_req", trap_req_o, 1);
    check("t6_id", trap_id_o, 10'h3FF);
    #3 rst_n = 1'b0;
    #1;
    check("t6_rst_req", trap_req_o, 0);
    check("t6_rst_ready", irq_ready_o, 0);
    check("t6_rst_id", trap_id_o, 0);
    check("t6_rst_lvl", trap_level_o, 0);
    check("t6_rst_mode", trap_mode_o, 0);
    check("t6_rst_shv", trap_shv_o, 0);
    check("t6_rst_mil", mil_o, 0);
    #1 rst_n = 1'b1;
    #1;
    check("t6_idle_req", trap_req_o, 0);
    check("t6_idle_ready", irq_ready_o, 1);
    irq_valid_i = 1'b0;
    step();
    check("t6_no_claim", trap_req_o, 0);
    claim(10'h12, 8'h33, 1'b0);
    do_mret(8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/clic_hart_if.md
CLIC_HART_IF -- requirements
Module: clic_hart_if

Interface
REQ-001 Parameter CLICINTCTLBITS, default 8, width of the level field and of mil/threshold.
REQ-002 Parameter NUM_INTR, default 1024, number of interrupt IDs; IDW = $clog2(NUM_INTR).
REQ-003 Parameter NEST_DEPTH, default 4, number of saved-level stack entries.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 irq_valid_i  input  1  CLIC has a highest-ranked pending, enabled interrupt.
REQ-007 irq_id_i  input  IDW  ID of that interrupt.
REQ-008 irq_level_i  input  CLICINTCTLBITS  level of that interrupt.
REQ-009 irq_mode_i  input  2  privilege mode of that interrupt.
REQ-010 irq_shv_i  input  1  selective hardware vectoring requested.
REQ-011 irq_ready_o  output  1  one-cycle claim pulse back to the CLIC.
REQ-012 mie_i  input  1  global interrupt enable from the hart.
REQ-013 mintthresh_i  input  CLICINTCTLBITS  level threshold.
REQ-014 trap_req_o  output  1  trap request to the core.
REQ-015 trap_id_o / trap_level_o / trap_mode_o / trap_shv_o  output  IDW / CLICINTCTLBITS / 2 / 1  captured request fields.
REQ-016 trap_ack_i  input  1  core has entered the handler.
REQ-017 mret_i  input  1  core executed mret (one-cycle pulse).
REQ-018 mil_o  output  CLICINTCTLBITS  current interrupt level.

Function
REQ-019 FSM states: IDLE, TRAP.
REQ-020 Accept condition: state IDLE, irq_valid_i=1, mie_i=1, irq_level_i > max(mil_o, mintthresh_i) as unsigned, stack not full.
REQ-021 On accept: irq_ready_o=1 in that same cycle (combinational); id/level/mode/shv registered; next state TRAP.
REQ-022 irq_ready_o SHALL be 0 in every cycle the accept condition is false.
REQ-023 In TRAP: trap_req_o=1 and trap_*_o hold the captured values, stable until trap_ack_i.
REQ-024 trap_ack_i=1 in TRAP: push current mil_o, set mil_o=captured level, return to IDLE next cycle; trap_req_o drops that next cycle.
REQ-025 trap_ack_i outside TRAP SHALL be ignored.
REQ-026 mret_i with non-empty stack: pop; mil_o = popped value next cycle.
REQ-027 mret_i with empty stack: mil_o = 0; stack unchanged.
REQ-028 mret_i in TRAP without trap_ack_i: pop applied; captured request remains pending and is not re-evaluated.
REQ-029 mret_i and trap_ack_i in the same cycle: push/level update of REQ-024 applied, mret_i ignored.
REQ-030 Stack full (NEST_DEPTH entries): no accept; irq_valid_i held by CLIC is not claimed until a pop.
REQ-031 mie_i or mintthresh_i changes while in TRAP SHALL NOT cancel the captured request.
REQ-032 Minimum accept-to-next-accept spacing is 2 cycles (accept, ack).

Reset
REQ-033 rst_n low: state IDLE, mil_o=0, stack empty, trap_req_o=0, irq_ready_o=0, trap_*_o=0, immediately and asynchronously.
REQ-034 Reset asserted in TRAP SHALL abandon the captured request without further ack to the CLIC.

Configuration
REQ-035 Macro CLIC_HART_NEST_STACK_EN defined: NEST_DEPTH-entry saved-level stack as in REQ-024..REQ-030.
REQ-036 Macro undefined: single saved-level register; accept additionally requires that register empty (no nesting); mret_i clears it and restores its value to mil_o.

Verification
REQ-037 mil=0, thresh=0, mie=1, valid id=5 level=0x40 -> ready pulse 1 cycle, trap_req next cycle with id 5, ack -> mil_o=0x40.
REQ-038 mil=0x40, request level=0x40 -> no ready; request level=0x41 -> accepted (macro defined), stack depth 2 after ack, mil=0x41.
REQ-039 thresh=0x80, request level=0x7F -> never claimed; mie=0 with level 0xFF -> never claimed.
REQ-040 Fill stack to NEST_DEPTH with rising levels -> next higher request not claimed; mret -> claimed on following IDLE cycle.
REQ-041 trap_ack and mret same cycle from mil=0x20 -> mil=captured level, stack grows by 1; mret on empty stack -> mil=0.
REQ-042 rst_n low mid-TRAP -> all outputs 0 asynchronously, IDLE after release; macro undefined -> second nested request refused until mret.
